// File: rtl/pipe_hazard_sched_if.sv
// Decode-side hazard controls and operand-forward selects
// shared between the pipeline and pipe_hazard_sched.
interface pipe_hazard_sched_if;
    logic [31:0] dec_ir;
    logic        dec_valid;
    logic        ex_taken;
    logic        mem_busy;
    logic        pc_write;
    logic        dec_en;
    logic        if_clear;
    logic        ex_clear;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output dec_ir, dec_valid, ex_taken, mem_busy,
        input  pc_write, dec_en, if_clear, ex_clear,
        input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_ir, dec_valid, ex_taken, mem_busy,
        output pc_write, dec_en, if_clear, ex_clear,
        output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_sched.sv
// OTTER 5-stage stall/flush/forward scheduler with EX/MEM/WB scoreboard.
// Define HZD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_sched #(
    parameter int LOAD_LAT  = 1,
    parameter int NREG_BITS = 5
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_sched_if.slave hz
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [1:0] LAT_M1   = 2'(LOAD_LAT - 1);

    typedef struct packed {
        logic                 valid;
        logic [NREG_BITS-1:0] rd;
        logic                 is_load;
    } slot_t;

    typedef enum logic [1:0] {RUN, LSTALL, HOLD} state_t;

    state_t state, state_n, saved, saved_n, eff;
    logic [1:0] cnt, cnt_n;
    slot_t sb_ex, sb_mem, sb_wb, dec_slot;

    logic [6:0] opc;
    logic [NREG_BITS-1:0] rs1, rs2, rd;
    logic use1, use2;
    logic ex1, ex2, mem1, mem2, load_use;
    logic [1:0] fa, fb, fwd_a_q, fwd_b_q;
    logic pc_write, dec_en, if_clear, ex_clear;

    assign opc = hz.dec_ir[6:0];
    assign rd  = hz.dec_ir[7 +: NREG_BITS];
    assign rs1 = hz.dec_ir[15 +: NREG_BITS];
    assign rs2 = hz.dec_ir[20 +: NREG_BITS];

    assign use1 = hz.dec_valid && rs1 != '0 &&
                  !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign use2 = hz.dec_valid && rs2 != '0 &&
                  (opc == OP_BR || opc == OP_ST || opc == OP_OP);

    assign dec_slot.valid   = hz.dec_valid && rd != '0 &&
                              !(opc == OP_BR || opc == OP_ST);
    assign dec_slot.rd      = rd;
    assign dec_slot.is_load = hz.dec_valid && opc == OP_LD;

    // slot.valid already excludes x0, so x0 can never match
    assign ex1  = use1 && sb_ex.valid  && sb_ex.rd  == rs1;
    assign ex2  = use2 && sb_ex.valid  && sb_ex.rd  == rs2;
    assign mem1 = use1 && sb_mem.valid && sb_mem.rd == rs1;
    assign mem2 = use2 && sb_mem.valid && sb_mem.rd == rs2;

    assign load_use = sb_ex.is_load && (ex1 || ex2);

    assign fa = (ex1 && !sb_ex.is_load) ? 2'b01 :
                mem1                    ? 2'b10 : 2'b00;
    assign fb = (ex2 && !sb_ex.is_load) ? 2'b01 :
                mem2                    ? 2'b10 : 2'b00;

    always_comb begin
        pc_write = 1'b1;
        dec_en   = 1'b1;
        if_clear = 1'b0;
        ex_clear = 1'b0;
        eff      = (state == HOLD) ? saved : state;
        state_n  = eff;
        saved_n  = saved;
        cnt_n    = cnt;
        if (rst) begin
            state_n = RUN;
        end else if (hz.mem_busy) begin
            pc_write = 1'b0;
            dec_en   = 1'b0;
            state_n  = HOLD;
            saved_n  = eff;
        end else if (hz.ex_taken) begin
            if_clear = 1'b1;
            ex_clear = 1'b1;
            state_n  = RUN;
            cnt_n    = '0;
        end else if (eff == LSTALL) begin
            pc_write = 1'b0;
            dec_en   = 1'b0;
            ex_clear = 1'b1;
            cnt_n    = cnt - 2'd1;
            state_n  = (cnt == 2'd1) ? RUN : LSTALL;
        end else if (load_use) begin
            // the detect cycle is the first bubble; LSTALL adds the rest
            pc_write = 1'b0;
            dec_en   = 1'b0;
            ex_clear = 1'b1;
            cnt_n    = LAT_M1;
            state_n  = (LOAD_LAT > 1) ? LSTALL : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            saved   <= RUN;
            cnt     <= '0;
            sb_ex   <= '0;
            sb_mem  <= '0;
            sb_wb   <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            state <= state_n;
            saved <= saved_n;
            cnt   <= cnt_n;
            if (!hz.mem_busy) begin
                sb_wb   <= sb_mem;
                sb_mem  <= sb_ex;
                sb_ex   <= ex_clear ? '0 : dec_slot;
                fwd_a_q <= ex_clear ? 2'b00 : fa;
                fwd_b_q <= ex_clear ? 2'b00 : fb;
            end
        end
    end

    assign hz.pc_write  = pc_write;
    assign hz.dec_en    = dec_en;
    assign hz.if_clear  = if_clear;
    assign hz.ex_clear  = ex_clear;
    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;

`ifdef HZD_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (!hz.mem_busy) begin
            if (!pc_write)
                stall_q <= stall_q + 32'd1;
            if (hz.ex_taken)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif
endmodule
